// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: RV32I load/store width
// codes, FSM state encoding and wait-counter width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } dmem_state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// MEM-stage <-> data memory controller request/response bundle.
// misalign_o exists only when DMEM_MISALIGN_EN is defined.
interface data_mem_ctrl_if;
  logic        data_ce_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_i;
  logic [2:0]  funct3_i;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        stall_o;
`ifdef DMEM_MISALIGN_EN
  logic        misalign_o;
`endif

  modport master (
    output data_ce_i, data_we_i, data_addr_i, data_i, funct3_i,
    input  data_o, data_valid_o, stall_o
`ifdef DMEM_MISALIGN_EN
    , input misalign_o
`endif
  );

  modport slave (
    input  data_ce_i, data_we_i, data_addr_i, data_i, funct3_i,
    output data_o, data_valid_o, stall_o
`ifdef DMEM_MISALIGN_EN
    , output misalign_o
`endif
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables/replicated data and
// load lane extract with sign/zero extension. DMEM_MISALIGN_EN adds misalign.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] read_word,
  output logic [3:0]  byte_en,
  output logic [31:0] write_data,
  output logic [31:0] load_data
`ifdef DMEM_MISALIGN_EN
  , output logic      misalign
`endif
);

  logic [1:0]  lane;
  logic [31:0] shifted;

  // Offsets below the access size are dropped, so accesses align down.
  always_comb begin
    lane       = '0;
    byte_en    = '1;
    write_data = store_data;
    case (funct3)
      F3_B, F3_BU: begin
        lane       = offset;
        byte_en    = 4'b0001 << offset;
        write_data = {4{store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        lane       = {offset[1], 1'b0};
        byte_en    = 4'b0011 << lane;
        write_data = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = read_word >> {lane, 3'b000};
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = read_word;
    endcase
  end

`ifdef DMEM_MISALIGN_EN
  always_comb begin
    case (funct3)
      F3_B, F3_BU: misalign = 1'b0;
      F3_H, F3_HU: misalign = offset[0];
      default:     misalign = (offset != 2'b00);
    endcase
  end
`endif

endmodule

// File: rtl/data_mem_ctrl.sv
// Wait-stated data memory controller behind the MEM stage; stalls the pipeline
// until each access completes. Optional feature macro: DMEM_MISALIGN_EN.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  data_mem_ctrl_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

  dmem_state_t            state, next_state;
  logic [WAIT_CNT_W-1:0]  cnt;
  logic                   cap_we;
  logic [ADDR_W+1:0]      cap_addr;
  logic [31:0]            cap_data;
  logic [2:0]             cap_funct3;
  logic [31:0]            data_q;

  logic                   sel_we;
  logic [ADDR_W+1:0]      sel_addr;
  logic [31:0]            sel_data;
  logic [2:0]             sel_funct3;
  logic [ADDR_W-1:0]      idx;
  logic                   enter_done;
  logic                   misalign;
  logic [3:0]             byte_en;
  logic [31:0]            write_data, load_data, read_word;

  logic [31:0] mem [DEPTH_WORDS];

  // With no wait states DONE is entered on the capture edge, so the live
  // request is used in IDLE and the captured one everywhere else.
  always_comb begin
    if (state == IDLE) begin
      sel_we     = bus.data_we_i;
      sel_addr   = bus.data_addr_i[ADDR_W+1:0];
      sel_data   = bus.data_i;
      sel_funct3 = bus.funct3_i;
    end else begin
      sel_we     = cap_we;
      sel_addr   = cap_addr;
      sel_data   = cap_data;
      sel_funct3 = cap_funct3;
    end
  end

  assign idx       = sel_addr[ADDR_W+1:2];
  assign read_word = mem[idx];

  dmem_lane_align u_lane (
    .funct3     (sel_funct3),
    .offset     (sel_addr[1:0]),
    .store_data (sel_data),
    .read_word  (read_word),
    .byte_en    (byte_en),
    .write_data (write_data),
    .load_data  (load_data)
`ifdef DMEM_MISALIGN_EN
    , .misalign (misalign)
`endif
  );

`ifndef DMEM_MISALIGN_EN
  assign misalign = 1'b0;
`endif

  always_comb begin
    next_state       = state;
    bus.stall_o      = 1'b0;
    bus.data_valid_o = 1'b0;
    case (state)
      IDLE: if (bus.data_ce_i) begin
        bus.stall_o = 1'b1;
        next_state  = (WAIT_CYCLES > 0) ? WAIT : DONE;
      end
      WAIT: begin
        bus.stall_o = 1'b1;
        if (cnt == '0) next_state = DONE;
      end
      DONE: begin
        bus.data_valid_o = 1'b1;
        next_state       = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign enter_done = (next_state == DONE) && (state != DONE);
  assign bus.data_o = data_q;
`ifdef DMEM_MISALIGN_EN
  assign bus.misalign_o = (state == DONE) && misalign;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_data   <= '0;
      cap_funct3 <= '0;
      data_q     <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && bus.data_ce_i) begin
        cap_we     <= bus.data_we_i;
        cap_addr   <= bus.data_addr_i[ADDR_W+1:0];
        cap_data   <= bus.data_i;
        cap_funct3 <= bus.funct3_i;
        cnt        <= WAIT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (enter_done && !sel_we)
        data_q <= misalign ? '0 : load_data;
    end
  end

  // Array has no reset; reset still blocks an in-flight store.
  always_ff @(posedge clk) begin
    if (!rst && enter_done && sel_we && !misalign) begin
      for (int unsigned i = 0; i < 4; i++)
        if (byte_en[i]) mem[idx][8*i +: 8] <= write_data[8*i +: 8];
    end
  end

endmodule
